// File: rtl/tagged_register_file.sv
// tagged_register_file
//   Architectural register file for the Tomasulo core. Every register holds a
//   value plus a producer tag (0 = value valid, otherwise the RS that will
//   write it). An issue reads two operands and renames the destination to the
//   issuing RS. All CDB ports retire results into waiting registers. A flush
//   drops every pending rename.
//
// Optional feature macro: REGFILE_CDB_BYPASS_EN
//   When defined, an issue read whose source tag matches a live CDB port on
//   the same edge returns that port's data as a valid operand. When undefined,
//   the read reports the pending tag and the issue logic snoops the CDB itself.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   issue                    read A/B and rename dest on this edge
//   A_address, B_address     operand register numbers
//   dest                     register renamed to RS_calculating_value
//   RS_calculating_value     tag of the producing RS (0 = read only)
//   write                    per-CDB-port valid
//   In_source, In_data       per-port tag / result, port k at slice k
//   flush                    clear all tags, zero the operand outputs
//   A_out, B_out             registered operand values
//   A_invalid, B_invalid     operand still pending
//   A_tag, B_tag             pending producer tag (0 when valid)
//   busy_count               number of registers with a non-zero tag
module tagged_register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int TAG_W    = 6,
   parameter int NUM_CDB  = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      issue,
   input  logic [ADDR_W-1:0]         A_address,
   input  logic [ADDR_W-1:0]         B_address,
   input  logic [ADDR_W-1:0]         dest,
   input  logic [TAG_W-1:0]          RS_calculating_value,
   input  logic [NUM_CDB-1:0]        write,
   input  logic [NUM_CDB*TAG_W-1:0]  In_source,
   input  logic [NUM_CDB*DATA_W-1:0] In_data,
   input  logic                      flush,
   output logic [DATA_W-1:0]         A_out,
   output logic [DATA_W-1:0]         B_out,
   output logic                      A_invalid,
   output logic                      B_invalid,
   output logic [TAG_W-1:0]          A_tag,
   output logic [TAG_W-1:0]          B_tag,
   output logic [ADDR_W:0]           busy_count
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int CNT_W    = ADDR_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic              invalid;
      logic [TAG_W-1:0]  tag;
   } operand_t;

   logic [NUM_REGS-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_REGS-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [CNT_W-1:0]                busy_count_q, busy_count_d;
   operand_t                        op_a_q, op_a_d;
   operand_t                        op_b_q, op_b_d;
   operand_t                        rd_a, rd_b;

   logic                            retire_hit;
   logic [DATA_W-1:0]               retire_val;
   logic                            rename_en;

   // Lowest-numbered live port carrying tag t. Iterating downwards lets the
   // lowest k overwrite any higher match. Tag 0 never matches.
   function automatic logic cdb_match(
      input  logic [TAG_W-1:0]          t,
      input  logic [NUM_CDB-1:0]        wr,
      input  logic [NUM_CDB*TAG_W-1:0]  src,
      input  logic [NUM_CDB*DATA_W-1:0] dat,
      output logic [DATA_W-1:0]         val
   );
      logic hit;
      hit = 1'b0;
      val = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (wr[k] && (t != '0) && (src[k*TAG_W +: TAG_W] == t)) begin
            hit = 1'b1;
            val = dat[k*DATA_W +: DATA_W];
         end
      end
      return hit;
   endfunction

   // Operand view of the pre-edge state; the zero register reads as valid 0.
   function automatic operand_t read_operand(
      input logic [ADDR_W-1:0]               addr,
      input logic [NUM_REGS-1:0][TAG_W-1:0]  tags,
      input logic [NUM_REGS-1:0][DATA_W-1:0] datas
   );
      operand_t r;
      r.val     = datas[addr];
      r.tag     = tags[addr];
      r.invalid = (tags[addr] != '0);
      if ((ZERO_REG != 0) && (addr == '0)) begin
         r = '0;
      end
      return r;
   endfunction

   // Register state update: CDB retire first, then flush or rename on top, so
   // a rename of dest beats a same-edge CDB clear while the data still lands.
   always_comb begin
      data_d       = data_q;
      tag_d        = tag_q;
      retire_hit   = 1'b0;
      retire_val   = '0;
      busy_count_d = '0;
      rename_en    = issue && (RS_calculating_value != '0) &&
                     !((ZERO_REG != 0) && (dest == '0));

      for (int r = 0; r < NUM_REGS; r++) begin
         retire_hit = cdb_match(tag_q[r], write, In_source, In_data, retire_val);
         if (retire_hit) begin
            data_d[r] = retire_val;
            tag_d[r]  = '0;
         end
      end

      if (flush) begin
         tag_d = '0;
      end else if (rename_en) begin
         tag_d[dest] = RS_calculating_value;
      end

      if (ZERO_REG != 0) begin
         data_d[0] = '0;
         tag_d[0]  = '0;
      end

      for (int r = 0; r < NUM_REGS; r++) begin
         busy_count_d = busy_count_d + CNT_W'(tag_d[r] != '0);
      end
   end

`ifdef REGFILE_CDB_BYPASS_EN
   logic              byp_a_hit, byp_b_hit;
   logic [DATA_W-1:0] byp_a_val, byp_b_val;
`endif

   // Operand capture: reads see the pre-edge mapping, so a source equal to
   // dest returns the old mapping. Outputs hold unless issue or flush.
   always_comb begin
      rd_a = read_operand(A_address, tag_q, data_q);
      rd_b = read_operand(B_address, tag_q, data_q);
`ifdef REGFILE_CDB_BYPASS_EN
      byp_a_hit = cdb_match(rd_a.tag, write, In_source, In_data, byp_a_val);
      byp_b_hit = cdb_match(rd_b.tag, write, In_source, In_data, byp_b_val);
      if (rd_a.invalid && byp_a_hit) begin
         rd_a = '{val: byp_a_val, invalid: 1'b0, tag: '0};
      end
      if (rd_b.invalid && byp_b_hit) begin
         rd_b = '{val: byp_b_val, invalid: 1'b0, tag: '0};
      end
`endif
      op_a_d = op_a_q;
      op_b_d = op_b_q;
      if (flush) begin
         op_a_d = '0;
         op_b_d = '0;
      end else if (issue) begin
         op_a_d = rd_a;
         op_b_d = rd_b;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q       <= '0;
         tag_q        <= '0;
         busy_count_q <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
      end else begin
         data_q       <= data_d;
         tag_q        <= tag_d;
         busy_count_q <= busy_count_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
      end
   end

   assign A_out      = op_a_q.val;
   assign A_invalid  = op_a_q.invalid;
   assign A_tag      = op_a_q.tag;
   assign B_out      = op_b_q.val;
   assign B_invalid  = op_b_q.invalid;
   assign B_tag      = op_b_q.tag;
   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_tagged_register_file.sv
module tb_tagged_register_file;

   logic        clock;
   logic        reset;
   logic        issue;
   logic [4:0]  A_address, B_address, dest;
   logic [5:0]  RS_calculating_value;
   logic [1:0]  write;
   logic [11:0] In_source;
   logic [63:0] In_data;
   logic        flush;
   logic [31:0] A_out, B_out;
   logic        A_invalid, B_invalid;
   logic [5:0]  A_tag, B_tag;
   logic [5:0]  busy_count;

   int total = 0;
   int bad   = 0;

   tagged_register_file dut (
      .clock(clock), .reset(reset), .issue(issue),
      .A_address(A_address), .B_address(B_address), .dest(dest),
      .RS_calculating_value(RS_calculating_value),
      .write(write), .In_source(In_source), .In_data(In_data), .flush(flush),
      .A_out(A_out), .B_out(B_out), .A_invalid(A_invalid), .B_invalid(B_invalid),
      .A_tag(A_tag), .B_tag(B_tag), .busy_count(busy_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", name, obs, exp);
   endtask

   // Advance one edge; outputs are then sampled 1ns after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      issue = 0; A_address = 0; B_address = 0; dest = 0;
      RS_calculating_value = 0; write = 0; In_source = 0; In_data = 0; flush = 0;
   endtask

   task automatic do_issue(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [5:0] t);
      issue = 1; A_address = a; B_address = b; dest = d; RS_calculating_value = t;
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      chk("rst_a_out", A_out, 0);
      chk("rst_a_inv", {31'd0, A_invalid}, 0);
      chk("rst_busy", {26'd0, busy_count}, 0);
      reset = 0;

      // 1: rename r3 -> tag 1, operands r1/r2 valid zero
      do_issue(1, 2, 3, 1); tick();
      chk("t1_a_out", A_out, 0);
      chk("t1_a_inv", {31'd0, A_invalid}, 0);
      chk("t1_b_inv", {31'd0, B_invalid}, 0);
      chk("t1_busy", {26'd0, busy_count}, 1);

      // 2: read r3 (pending tag 1), r7 read before its own rename
      do_issue(3, 7, 7, 2); tick();
      chk("t2_a_inv", {31'd0, A_invalid}, 1);
      chk("t2_a_tag", {26'd0, A_tag}, 1);
      chk("t2_b_inv", {31'd0, B_invalid}, 0);
      chk("t2_b_out", B_out, 0);
      chk("t2_busy", {26'd0, busy_count}, 2);

      // 3: retire tag 1 with 25; outputs hold without issue
      idle(); write = 2'b01; In_source = {6'd0, 6'd1}; In_data = {32'd0, 32'd25}; tick();
      chk("t3_busy", {26'd0, busy_count}, 1);
      chk("t3_hold_inv", {31'd0, A_invalid}, 1);
      chk("t3_hold_tag", {26'd0, A_tag}, 1);
      idle(); do_issue(3, 0, 0, 0); tick();
      chk("t3_a_out", A_out, 25);
      chk("t3_a_inv", {31'd0, A_invalid}, 0);

      // 4: issue reading r7 while CDB port 1 retires tag 2; r7 renamed to 3
      idle(); do_issue(7, 3, 7, 3);
      write = 2'b10; In_source = {6'd2, 6'd0}; In_data = {32'd21, 32'd0}; tick();
`ifdef REGFILE_CDB_BYPASS_EN
      chk("t4_a_out", A_out, 21);
      chk("t4_a_inv", {31'd0, A_invalid}, 0);
`else
      chk("t4_a_inv", {31'd0, A_invalid}, 1);
      chk("t4_a_tag", {26'd0, A_tag}, 2);
`endif
      chk("t4_busy", {26'd0, busy_count}, 1);
      idle(); do_issue(7, 0, 0, 0); tick();
      chk("t4_r7_tag", {26'd0, A_tag}, 3);
      chk("t4_r7_data", A_out, 21);

      // duplicate tag on both ports: port 0 wins
      idle(); write = 2'b11; In_source = {6'd3, 6'd3}; In_data = {32'd66, 32'd55}; tick();
      chk("dup_busy", {26'd0, busy_count}, 0);
      idle(); do_issue(7, 1, 0, 0); tick();
      chk("dup_r7", A_out, 55);

      // write with source tag 0 touches nothing
      idle(); write = 2'b01; In_source = {6'd0, 6'd0}; In_data = {32'd0, 32'd99}; tick();
      idle(); do_issue(1, 2, 0, 0); tick();
      chk("src0_r1", A_out, 0);

      // 5: r4 -> 5, r5 -> 6, both retired on one edge
      idle(); do_issue(0, 0, 4, 5); tick();
      do_issue(0, 0, 5, 6); tick();
      chk("t5_busy2", {26'd0, busy_count}, 2);
      idle(); write = 2'b11; In_source = {6'd6, 6'd5};
      In_data = {32'd100, 32'hFFFF_FFF9}; tick();
      chk("t5_busy0", {26'd0, busy_count}, 0);
      idle(); do_issue(4, 5, 0, 0); tick();
      chk("t5_a_out", A_out, 32'hFFFF_FFF9);
      chk("t5_b_out", B_out, 100);
      chk("t5_b_inv", {31'd0, B_invalid}, 0);

      // 6: two pending, then flush with an ignored issue and a CDB write
      idle(); do_issue(0, 0, 8, 10); tick();
      do_issue(0, 0, 9, 11); tick();
      chk("t6_busy2", {26'd0, busy_count}, 2);
      idle(); do_issue(8, 4, 1, 12); flush = 1;
      write = 2'b01; In_source = {6'd0, 6'd10}; In_data = {32'd0, 32'd77}; tick();
      chk("t6_fl_busy", {26'd0, busy_count}, 0);
      chk("t6_fl_a_out", A_out, 0);
      chk("t6_fl_b_out", B_out, 0);
      chk("t6_fl_a_inv", {31'd0, A_invalid}, 0);
      idle(); do_issue(8, 9, 0, 0); tick();
      chk("t6_r8", A_out, 77);
      chk("t6_r9_inv", {31'd0, B_invalid}, 0);
      idle(); do_issue(0, 0, 0, 9); tick();
      chk("t6_zero_busy", {26'd0, busy_count}, 0);
      chk("t6_zero_out", A_out, 0);

      // async reset between edges
      idle(); do_issue(8, 5, 2, 4); tick();
      chk("t6_pre_a", A_out, 77);
      chk("t6_pre_busy", {26'd0, busy_count}, 1);
      idle();
      #2 reset = 1;
      #1;
      chk("t6_ar_a", A_out, 0);
      chk("t6_ar_b", B_out, 0);
      chk("t6_ar_busy", {26'd0, busy_count}, 0);
      tick();
      reset = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
